// File: rtl/qsn_cyclic_shift_pipe.sv
// qsn_cyclic_shift_pipe: three-stage quasi-cyclic shift network (left/right split then merge) with valid/ready flow control.
module qsn_cyclic_shift_pipe #(
  parameter int LANES   = 8,
  parameter int MSG_W   = 4,
  parameter int SHIFT_W = 3
) (
  input  logic                     sys_clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [LANES*MSG_W-1:0]   data_in,
  input  logic [SHIFT_W-1:0]       shift_amt,
  input  logic [SHIFT_W:0]         z_size,
  input  logic                     dir,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [LANES*MSG_W-1:0]   data_out,
  output logic                     cfg_err
);
  localparam int ZW = SHIFT_W + 1;
  typedef logic [LANES-1:0][MSG_W-1:0] vec_t;
  logic          stall, adv, in_err;
  logic [ZW-1:0] in_e, right_sel;
  vec_t          left_n, right_n, merge_n;
  logic          s1_v_q, s1_v_d, s1_err_q, s1_err_d;
  logic [ZW-1:0] s1_z_q, s1_z_d, s1_e_q, s1_e_d;
  vec_t          s1_data_q, s1_data_d;
  logic          s2_v_q, s2_v_d, s2_err_q, s2_err_d;
  logic [ZW-1:0] s2_z_q, s2_z_d, s2_mb_q, s2_mb_d;
  vec_t          s2_left_q, s2_left_d, s2_right_q, s2_right_d;
  logic          out_valid_q, out_valid_d, cfg_err_q, cfg_err_d;
  vec_t          data_out_q, data_out_d;
  // A down-rotate by s equals an up-rotate by Z-s, so both directions share one network.
  always_comb begin
    stall = out_valid_q && !out_ready;
    adv = !stall;
    in_err = z_size == '0 || z_size > ZW'(LANES) || {1'b0, shift_amt} >= z_size;
    in_e = (!dir || shift_amt == '0) ? {1'b0, shift_amt} : z_size - {1'b0, shift_amt};
    right_sel = s1_z_q - s1_e_q;
    left_n = '0;
    right_n = '0;
    merge_n = '0;
    for (int j = 0; j < LANES; j++)
      for (int k = 0; k < LANES; k++) begin
        if (k >= j && ZW'(k - j) == s1_e_q) left_n[j] = s1_data_q[k];
        if (k <= j && ZW'(j - k) == right_sel) right_n[j] = s1_data_q[k];
      end
    for (int j = 0; j < LANES; j++)
      if (!s2_err_q && ZW'(j) < s2_z_q) merge_n[j] = ZW'(j) < s2_mb_q ? s2_left_q[j] : s2_right_q[j];
    s1_v_d      = adv ? in_valid : s1_v_q;
    s1_data_d   = adv ? vec_t'(data_in) : s1_data_q;
    s1_z_d      = adv ? z_size : s1_z_q;
    s1_e_d      = adv ? in_e : s1_e_q;
    s1_err_d    = adv ? in_err : s1_err_q;
    s2_v_d      = adv ? s1_v_q : s2_v_q;
    s2_left_d   = adv ? left_n : s2_left_q;
    s2_right_d  = adv ? right_n : s2_right_q;
    s2_z_d      = adv ? s1_z_q : s2_z_q;
    s2_mb_d     = adv ? right_sel : s2_mb_q;
    s2_err_d    = adv ? s1_err_q : s2_err_q;
    out_valid_d = adv ? s2_v_q : out_valid_q;
    data_out_d  = adv ? merge_n : data_out_q;
    cfg_err_d   = adv ? s2_err_q : cfg_err_q;
  end
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      s1_v_q      <= 1'b0;
      s1_data_q   <= '0;
      s1_z_q      <= '0;
      s1_e_q      <= '0;
      s1_err_q    <= 1'b0;
      s2_v_q      <= 1'b0;
      s2_left_q   <= '0;
      s2_right_q  <= '0;
      s2_z_q      <= '0;
      s2_mb_q     <= '0;
      s2_err_q    <= 1'b0;
      out_valid_q <= 1'b0;
      data_out_q  <= '0;
      cfg_err_q   <= 1'b0;
    end else begin
      s1_v_q      <= s1_v_d;
      s1_data_q   <= s1_data_d;
      s1_z_q      <= s1_z_d;
      s1_e_q      <= s1_e_d;
      s1_err_q    <= s1_err_d;
      s2_v_q      <= s2_v_d;
      s2_left_q   <= s2_left_d;
      s2_right_q  <= s2_right_d;
      s2_z_q      <= s2_z_d;
      s2_mb_q     <= s2_mb_d;
      s2_err_q    <= s2_err_d;
      out_valid_q <= out_valid_d;
      data_out_q  <= data_out_d;
      cfg_err_q   <= cfg_err_d;
    end
  end
  assign in_ready  = !stall;
  assign out_valid = out_valid_q;
  assign data_out  = data_out_q;
  assign cfg_err   = cfg_err_q;
endmodule
